// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops plus
// iterative shift-add multiply and restoring divide (one bit per cycle).
module alu_multicycle #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic [SHW-1:0]   shamt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             zero_o
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SRLV = 4'b0011;
   localparam logic [3:0] OP_DIVU = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_BGT  = 4'b1001;
   localparam logic [3:0] OP_BGE  = 4'b1010;
   localparam logic [3:0] OP_BEQ  = 4'b1011;
   localparam logic [3:0] OP_LUI  = 4'b1100;
   localparam logic [3:0] OP_SLL  = 4'b1101;
   localparam logic [3:0] OP_BNE  = 4'b1110;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             div_q, div_d;
   logic [WIDTH-1:0] acc_q, acc_d;      // product high word / partial remainder
   logic [WIDTH-1:0] lo_q, lo_d;        // multiplier shifting out / dividend -> quotient
   logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] iter_acc;
   logic [WIDTH-1:0] iter_lo;

   // Result of every single-cycle opcode; unused codes give zero.
   function automatic logic [WIDTH-1:0] single_op(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [SHW-1:0]   sh);
      logic [WIDTH-1:0] r;
      r = '0;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_SLT:  r = WIDTH'($signed(a) <  $signed(b));
         OP_BGT:  r = WIDTH'($signed(a) >  $signed(b));
         OP_BGE:  r = WIDTH'($signed(a) >= $signed(b));
         OP_BEQ:  r = WIDTH'(a == b);
         OP_BNE:  r = WIDTH'(a != b);
         OP_SRLV: r = a >> b[SHW-1:0];
         OP_LUI:  r = b << (WIDTH / 2);
         OP_SLL:  r = b << sh;
         default: r = '0;
      endcase
      return r;
   endfunction

   // One radix-2 step of either shift-add multiply or restoring divide.
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_diff = {acc_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
      iter_acc = acc_q;
      iter_lo  = lo_q;
      if (div_q) begin
         if (!div_diff[WIDTH]) begin
            iter_acc = div_diff[WIDTH-1:0];
            iter_lo  = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            iter_acc = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
            iter_lo  = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         iter_acc = mul_sum[WIDTH:1];
         iter_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Next-state and datapath-load decisions.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      hi_d     = hi_q;
      zero_d   = zero_q;
      case (state_q)
         CALC: begin
            acc_d = iter_acc;
            lo_d  = iter_lo;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH - 1)) begin
               state_d  = DONE;
               cnt_d    = '0;
               result_d = iter_lo;
               hi_d     = iter_acc;
               zero_d   = (iter_lo == '0);
            end
         end
         default: begin
            state_d = IDLE;
            if (start_i) begin
               if (ctrl_i == OP_MULU || ctrl_i == OP_DIVU) begin
                  state_d = CALC;
                  cnt_d   = '0;
                  div_d   = (ctrl_i == OP_DIVU);
                  acc_d   = '0;
                  lo_d    = src1_i;
                  opnd_d  = src2_i;
               end else begin
                  state_d  = DONE;
                  result_d = single_op(ctrl_i, src1_i, src2_i, shamt_i);
                  hi_d     = '0;
                  zero_d   = (single_op(ctrl_i, src1_i, src2_i, shamt_i) == '0);
               end
            end
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         acc_q    <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         hi_q     <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         zero_q   <= zero_d;
      end
   end

   assign busy_o   = (state_q == CALC);
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;
   assign hi_o     = hi_q;
   assign zero_o   = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32): directed cases plus random ops.
module tb_alu_multicycle;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [3:0]  ctrl_i = '0;
   logic [31:0] src1_i = '0;
   logic [31:0] src2_i = '0;
   logic [4:0]  shamt_i = '0;
   logic        busy_o, done_o, zero_o;
   logic [31:0] result_o, hi_o;

   alu_multicycle #(.WIDTH(32), .SHW(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ctrl_i(ctrl_i),
      .src1_i(src1_i), .src2_i(src2_i), .shamt_i(shamt_i),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .hi_o(hi_o),
      .zero_o(zero_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          free_edge = 0;
   int          busy_lo = 0;
   int          busy_hi = -1;
   logic        rst_at_edge = 1'b0;
   logic [31:0] last_res = '0;
   logic [31:0] last_hi = '0;

   always @(posedge clk_i) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst_i;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // Reference behaviour straight from the opcode table.
   function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] sh,
                                     output logic [31:0] res, output logic [31:0] hi);
      logic [63:0] p;
      logic [4:0]  bs;
      bs  = b[4:0];
      res = '0;
      hi  = '0;
      case (op)
         4'b0000: res = a & b;
         4'b0001: res = a | b;
         4'b0010: res = a + b;
         4'b0110: res = a - b;
         4'b0111: res = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
         4'b1001: res = ($signed(a) >  $signed(b)) ? 32'd1 : 32'd0;
         4'b1010: res = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         4'b1011: res = (a == b) ? 32'd1 : 32'd0;
         4'b1110: res = (a != b) ? 32'd1 : 32'd0;
         4'b0011: res = a >> bs;
         4'b1100: res = b << 16;
         4'b1101: res = b << sh;
         4'b1000: begin
            p   = 64'(a) * 64'(b);
            res = p[31:0];
            hi  = p[63:32];
         end
         4'b0100: begin
            if (b == 32'd0) begin
               res = 32'hFFFF_FFFF;
               hi  = a;
            end else begin
               res = a / b;
               hi  = a % b;
            end
         end
         default: begin
            res = '0;
            hi  = '0;
         end
      endcase
   endfunction

   // Drive start for one edge; book the expected response if the ALU is free.
   task automatic step_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh, input bit ovr,
                             input logic [31:0] er, input logic [31:0] eh);
      exp_t e;
      int   acc;
      bit   multi;
      start_i = 1'b1;
      ctrl_i  = op;
      src1_i  = a;
      src2_i  = b;
      shamt_i = sh;
      acc     = cyc + 1;
      if (acc >= free_edge) begin
         multi = (op == 4'b1000) || (op == 4'b0100);
         ref_model(op, a, b, sh, e.res, e.hi);
         if (ovr) begin
            e.res = er;
            e.hi  = eh;
         end
         e.cyc = acc + (multi ? 32 : 0);
         sb.push_back(e);
         free_edge = acc + (multi ? 33 : 1);
         if (multi) begin
            busy_lo = acc;
            busy_hi = acc + 31;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      start_i = 1'b0;
      ctrl_i  = 4'($urandom);
      src1_i  = $urandom;
      src2_i  = $urandom;
      shamt_i = 5'($urandom);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic do_reset(input bit with_start);
      rst_i   = 1'b1;
      start_i = with_start;
      ctrl_i  = 4'b1000;
      @(posedge clk_i);
      sb.delete();
      busy_hi   = -1;
      free_edge = cyc + 1;
      #1;
      rst_i   = 1'b0;
      start_i = 1'b0;
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 15));
         1: case ($urandom_range(0, 3))
               0: return 32'h0000_0000;
               1: return 32'hFFFF_FFFF;
               2: return 32'h8000_0000;
               default: return 32'h7FFF_FFFF;
            endcase
         default: return $urandom;
      endcase
   endfunction

   // Monitor: reset values, busy window, done timing/values, output hold.
   always @(negedge clk_i) begin : monitor
      exp_t e;
      logic exp_busy;
      if (rst_at_edge) begin
         chk("rst_busy", 64'(busy_o), 64'd0);
         chk("rst_done", 64'(done_o), 64'd0);
         chk("rst_result", 64'(result_o), 64'd0);
         chk("rst_hi", 64'(hi_o), 64'd0);
         chk("rst_zero", 64'(zero_o), 64'd1);
         last_res = '0;
         last_hi  = '0;
      end else begin
         exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
         chk("busy", 64'(busy_o), 64'(exp_busy));
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_done cyc=%0d want_cyc=%0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (done_o) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done cyc=%0d result=%h", cyc, result_o);
            end else begin
               e = sb.pop_front();
               chk("done_cyc", 64'(cyc), 64'(e.cyc));
               chk("result", 64'(result_o), 64'(e.res));
               chk("hi", 64'(hi_o), 64'(e.hi));
               chk("zero", 64'(zero_o), 64'(e.res == 32'd0));
            end
            last_res = result_o;
            last_hi  = hi_o;
         end else begin
            chk("hold_result", 64'(result_o), 64'(last_res));
            chk("hold_hi", 64'(hi_o), 64'(last_hi));
         end
      end
   end

   initial begin
      int t;
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i     = 1'b0;
      free_edge = cyc + 1;

      // Directed corner cases.
      step_start(4'b0010, 32'd7, 32'hFFFF_FFFD, 5'd0, 1'b1, 32'd4, 32'd0);
      idle(1);
      step_start(4'b1000, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b1, 32'hFFFF_FFFE, 32'd1);
      idle(34);
      step_start(4'b0100, 32'd100, 32'd7, 5'd0, 1'b1, 32'd14, 32'd2);
      idle(34);
      step_start(4'b0100, 32'd5, 32'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'd5);
      idle(34);
      step_start(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1, 32'd1, 32'd0);
      idle(1);
      step_start(4'b1010, 32'd5, 32'd5, 5'd0, 1'b1, 32'd1, 32'd0);
      idle(1);
      step_start(4'b0110, 32'd5, 32'd5, 5'd0, 1'b1, 32'd0, 32'd0);
      idle(1);
      step_start(4'b1100, 32'd0, 32'h0000_1234, 5'd0, 1'b1, 32'h1234_0000, 32'd0);
      idle(1);
      step_start(4'b1101, 32'd0, 32'h0000_0003, 5'd4, 1'b1, 32'h0000_0030, 32'd0);
      idle(1);
      step_start(4'b1111, 32'd9, 32'd9, 5'd0, 1'b1, 32'd0, 32'd0);
      idle(2);

      // Start while busy is ignored; start held through DONE chains ops.
      step_start(4'b1000, 32'd3, 32'd5, 5'd0, 1'b1, 32'd15, 32'd0);
      idle(3);
      step_start(4'b0100, 32'd100, 32'd7, 5'd0, 1'b0, '0, '0);
      idle(35);
      step_start(4'b1000, 32'd6, 32'd7, 5'd0, 1'b1, 32'd42, 32'd0);
      repeat (33) step_start(4'b0010, 32'd1, 32'd2, 5'd0, 1'b1, 32'd3, 32'd0);
      step_start(4'b0010, 32'd10, 32'd20, 5'd0, 1'b1, 32'd30, 32'd0);
      idle(2);

      // Reset mid-multiply with a simultaneous start: aborted, no done.
      step_start(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, '0, '0);
      idle(9);
      do_reset(1'b1);
      idle(40);

      // Randomized traffic, including starts that land while busy.
      for (int i = 0; i < 250; i++) begin
         step_start(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(),
                    5'($urandom), 1'b0, '0, '0);
         t = $urandom_range(0, 3);
         if (t != 0) idle(t);
      end

      t = 0;
      idle(0);
      while (sb.size() > 0 && t < 200) begin
         @(posedge clk_i);
         #1;
         t++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
